// File: rtl/deserializer_pkg.sv
// Shared types and constants for the deserializer and its training FSM.
package deserializer_pkg;

  localparam int LOCK_CNT_W = 4;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    SLIP    = 2'd1,
    DISCARD = 2'd2,
    LOCKED  = 2'd3
  } train_state_e;

endpackage

// File: rtl/deserializer_train_fsm.sv
// Word-boundary training: compares committed words against a known pattern,
// slips one beat per mismatch and locks after LOCK_COUNT consecutive matches.
module deserializer_train_fsm
  import deserializer_pkg::*;
#(
  parameter int              D          = 8,
  parameter int              S          = 8,
  parameter logic [D*S-1:0]  TRAIN_WORD = 64'h0706050403020100,
  parameter int              LOCK_COUNT = 4,
  parameter int              CW         = $clog2(S)
) (
  input  logic             high_speed_clock,
  input  logic             reset,
  input  logic             commit,
  input  logic [D*S-1:0]   word,
  input  logic [CW-1:0]    cnt,
  output logic             slip_req,
  output logic             locked
);

  train_state_e           state_q, state_d;
  logic [LOCK_CNT_W-1:0]  match_cnt_q, match_cnt_d;
  logic                   frame_end_s;

  assign frame_end_s = commit && (cnt == CW'(S - 1));
  assign slip_req    = (state_q == SLIP);
  assign locked      = (state_q == LOCKED);

  // State and match-counter registers.
  always_ff @(posedge high_speed_clock) begin
    if (reset) begin
      state_q     <= SEARCH;
      match_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  // Next-state logic; SLIP lasts exactly one cycle, DISCARD drops the partial frame.
  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    case (state_q)
      SEARCH: begin
        if (frame_end_s) begin
          if (word == TRAIN_WORD) begin
            match_cnt_d = match_cnt_q + LOCK_CNT_W'(1);
            if ((match_cnt_q + LOCK_CNT_W'(1)) == LOCK_CNT_W'(LOCK_COUNT)) begin
              state_d = LOCKED;
            end else begin
              state_d = SEARCH;
            end
          end else begin
            match_cnt_d = '0;
            state_d     = SLIP;
          end
        end else begin
          state_d = SEARCH;
        end
      end
      SLIP:    state_d = DISCARD;
      DISCARD: begin
        if (frame_end_s) begin
          state_d = SEARCH;
        end else begin
          state_d = DISCARD;
        end
      end
      LOCKED:  state_d = LOCKED;
      default: state_d = SEARCH;
    endcase
  end

endmodule

// File: rtl/deserializer.sv
// Reassembles S consecutive D-bit beats into one word, with beat-slip alignment.
// Define DESERIALIZER_TRAINING_EN to add automatic boundary training.
module deserializer
  import deserializer_pkg::*;
#(
  parameter int              D          = 8,
  parameter int              S          = 8,
  parameter logic [D*S-1:0]  TRAIN_WORD = 64'h0706050403020100,
  parameter int              LOCK_COUNT = 4
) (
  input  logic                   high_speed_clock,
  input  logic                   reset,
  input  logic [D-1:0]           data_in,
  input  logic                   bitslip,
  output logic [D*S-1:0]         data_out,
  output logic                   data_valid,
  output logic [$clog2(S)-1:0]   beat_index,
  output logic                   locked
);

  localparam int CW = $clog2(S);

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [D*S-1:0]  asm_q, asm_d;
  logic [D*S-1:0]  data_out_q, data_out_d;
  logic            data_valid_q, data_valid_d;
  logic            slip_s, commit_s, locked_s;

`ifdef DESERIALIZER_TRAINING_EN
  logic slip_req_s;

  deserializer_train_fsm #(
    .D          (D),
    .S          (S),
    .TRAIN_WORD (TRAIN_WORD),
    .LOCK_COUNT (LOCK_COUNT),
    .CW         (CW)
  ) u_train_fsm (
    .high_speed_clock (high_speed_clock),
    .reset            (reset),
    .commit           (commit_s),
    .word             (data_out_d),
    .cnt              (cnt_q),
    .slip_req         (slip_req_s),
    .locked           (locked_s)
  );

  // Once locked the boundary is frozen, so neither slip source is honoured.
  assign slip_s = (bitslip | slip_req_s) & ~locked_s;
`else
  logic unused_cfg_s;

  assign unused_cfg_s = ^{TRAIN_WORD, LOCK_CNT_W'(LOCK_COUNT)};
  assign locked_s     = 1'b1;
  assign slip_s       = bitslip;
`endif

  assign commit_s   = (cnt_q == CW'(S - 1)) && !slip_s;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign beat_index = cnt_q;
  assign locked     = locked_s;

  // Slot counter, assembly buffer and output word next-state.
  always_comb begin
    asm_d                 = asm_q;
    asm_d[cnt_q*D +: D]   = data_in;
    data_valid_d          = commit_s;
    if (slip_s) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    // The last beat bypasses the buffer so the word is out with zero latency.
    if (commit_s) begin
      data_out_d = {data_in, asm_q[D*(S-1)-1:0]};
    end else begin
      data_out_d = data_out_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge high_speed_clock) begin
    if (reset) begin
      cnt_q        <= '0;
      asm_q        <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      asm_q        <= asm_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// Directed, table-driven bench for deserializer (D=8, S=8); covers the
// training build as well when DESERIALIZER_TRAINING_EN is defined.
module tb_deserializer;

  localparam logic [63:0] TW = 64'h0706050403020100;
`ifdef DESERIALIZER_TRAINING_EN
  localparam logic EXP_LOCK_RST = 1'b0;
`else
  localparam logic EXP_LOCK_RST = 1'b1;
`endif

  logic        clk     = 1'b0;
  logic        reset   = 1'b1;
  logic        bitslip = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic [63:0] data_out;
  logic        data_valid;
  logic [2:0]  beat_index;
  logic        locked;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0]  din;
    logic        slip;
    logic [63:0] exp_out;
    logic        exp_valid;
    logic [2:0]  exp_idx;
  } vec_t;

  vec_t vecs[16];

  deserializer dut (
    .high_speed_clock (clk),
    .reset            (reset),
    .data_in          (data_in),
    .bitslip          (bitslip),
    .data_out         (data_out),
    .data_valid       (data_valid),
    .beat_index       (beat_index),
    .locked           (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one beat, let one rising edge take it, then settle before sampling.
  task automatic beat(input logic [7:0] d, input logic s);
    data_in = d;
    bitslip = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    beat(8'hA5, 1'b0);
    beat(8'hA5, 1'b0);
    chk("rst_data_out", data_out, 64'h0);
    chk("rst_valid", 64'(data_valid), 64'h0);
    chk("rst_beat_index", 64'(beat_index), 64'h0);
    chk("rst_locked", 64'(locked), 64'(EXP_LOCK_RST));
    reset = 1'b0;

    // Basic assembly: beats 0..7 twice, one valid pulse per 8 beats
    for (int k = 0; k < 16; k++) begin
      vecs[k].din       = 8'(k % 8);
      vecs[k].slip      = 1'b0;
      vecs[k].exp_out   = (k >= 7) ? TW : 64'h0;
      vecs[k].exp_valid = ((k % 8) == 7);
      vecs[k].exp_idx   = 3'((k + 1) % 8);
    end
    for (int k = 0; k < 16; k++) begin
      beat(vecs[k].din, vecs[k].slip);
      chk($sformatf("tbl%0d_out", k), data_out, vecs[k].exp_out);
      chk($sformatf("tbl%0d_valid", k), 64'(data_valid), 64'(vecs[k].exp_valid));
      chk($sformatf("tbl%0d_idx", k), 64'(beat_index), 64'(vecs[k].exp_idx));
    end

    // Reset mid-frame: partial word is dropped, next word from post-reset beats only
    for (int k = 0; k < 3; k++) beat(8'hAA, 1'b0);
    reset = 1'b1;
    beat(8'h55, 1'b0);
    chk("midrst_out", data_out, 64'h0);
    chk("midrst_valid", 64'(data_valid), 64'h0);
    chk("midrst_idx", 64'(beat_index), 64'h0);
    reset = 1'b0;
    for (int k = 0; k < 7; k++) beat(8'(k), 1'b0);
    chk("midrst_early_valid", 64'(data_valid), 64'h0);
    chk("midrst_early_out", data_out, 64'h0);
    beat(8'h07, 1'b0);
    chk("midrst_word_valid", 64'(data_valid), 64'h1);
    chk("midrst_word_out", data_out, TW);

`ifndef DESERIALIZER_TRAINING_EN
    // One-beat offset stream, then a single manual slip realigns it
    for (int k = 0; k < 16; k++) begin
      beat(8'((k + 7) % 8), 1'b0);
      if ((k % 8) == 7) begin
        chk($sformatf("off%0d_out", k), data_out, 64'h0605040302010007);
        chk($sformatf("off%0d_valid", k), 64'(data_valid), 64'h1);
      end
    end
    beat(8'h07, 1'b1);
    chk("slip_idx_hold", 64'(beat_index), 64'h0);
    chk("slip_no_valid", 64'(data_valid), 64'h0);
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 8; k++) beat(8'(k), 1'b0);
      chk($sformatf("aligned%0d_out", f), data_out, TW);
      chk($sformatf("aligned%0d_valid", f), 64'(data_valid), 64'h1);
    end

    // Slip at frame end: commit suppressed, next pulse 9 cycles after the last
    for (int k = 0; k < 7; k++) begin
      beat(8'(k), 1'b0);
      chk($sformatf("endslip_gap%0d_valid", k), 64'(data_valid), 64'h0);
    end
    beat(8'hEE, 1'b1);
    chk("endslip_suppressed", 64'(data_valid), 64'h0);
    chk("endslip_idx", 64'(beat_index), 64'h7);
    beat(8'h07, 1'b0);
    chk("endslip_late_valid", 64'(data_valid), 64'h1);
    chk("endslip_late_out", data_out, TW);
`else
    // Serializer loopback: its registered output adds one idle beat after reset
    begin
      int holds;
      logic [2:0] prev_idx;
      holds = 0;
      reset = 1'b1;
      beat(8'h00, 1'b0);
      reset = 1'b0;
      for (int c = 0; c <= 56; c++) begin
        prev_idx = beat_index;
        beat((c == 0) ? 8'h00 : 8'((c - 1) % 8), 1'b0);
        if (beat_index == prev_idx) holds++;
        if (c == 47) chk("train_locked_early", 64'(locked), 64'h0);
        if (c == 48) begin
          chk("train_locked", 64'(locked), 64'h1);
          chk("train_lock_valid", 64'(data_valid), 64'h1);
          chk("train_lock_out", data_out, TW);
        end
      end
      chk("train_slip_count", 64'(holds), 64'h1);
    end

    // Post-lock: corrupt word plus bitslip must not disturb the boundary
    beat(8'hFF, 1'b1);
    chk("postlock_idx_advances", 64'(beat_index), 64'h1);
    chk("postlock_locked0", 64'(locked), 64'h1);
    for (int k = 1; k < 8; k++) beat(8'hFF, 1'b0);
    chk("postlock_bad_valid", 64'(data_valid), 64'h1);
    chk("postlock_bad_out", data_out, 64'hFFFFFFFFFFFFFFFF);
    chk("postlock_locked1", 64'(locked), 64'h1);
    for (int k = 0; k < 8; k++) beat(8'(k), 1'b0);
    chk("postlock_clean_out", data_out, TW);
    chk("postlock_clean_valid", 64'(data_valid), 64'h1);
    chk("postlock_locked2", 64'(locked), 64'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
